// File: rtl/axi_slv_mem_if.sv
// AXI bus bundle between a VIP master and the slave memory; widths follow the memory's parameters.
interface axi_slv_mem_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ID_WIDTH-1:0]     AWID;
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic [7:0]              AWLEN;
   logic [2:0]              AWSIZE;
   logic [1:0]              AWBURST;
   logic [2:0]              AWPROT;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [ID_WIDTH-1:0]     WID;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WLAST;
   logic                    WVALID;
   logic                    WREADY;
   logic [ID_WIDTH-1:0]     BID;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;
   logic [ID_WIDTH-1:0]     ARID;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic [7:0]              ARLEN;
   logic [2:0]              ARSIZE;
   logic [1:0]              ARBURST;
   logic [2:0]              ARPROT;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [ID_WIDTH-1:0]     RID;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RLAST;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID, input AWREADY,
      output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
      input BID, BRESP, BVALID, output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID, input ARREADY,
      input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
   );

   modport slave (
      input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWPROT, AWVALID, output AWREADY,
      input WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
      output BID, BRESP, BVALID, input BREADY,
      input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARPROT, ARVALID, output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
   );
endinterface

// File: rtl/axi_slv_mem.sv
// AXI slave memory: independent write/read FSMs, one burst each, FIXED/INCR/WRAP, WSTRB, SLVERR.
// All outputs registered; RDATA for a beat is fetched at the edge that accepts AR or the previous R beat.
module axi_slv_mem #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input logic          ACLK,
   input logic          ARESET,
   axi_slv_mem_if.slave s_axi
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LB     = $clog2(STRB_W);
   localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_ADDR, R_DATA} r_state_e;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] mask;
      step = ADDR_WIDTH'(1) << size;
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b00:   next_addr = a;
         2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
         default: next_addr = a + step;
      endcase
   endfunction

   function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
         input logic [1:0] burst);
      burst_err = (size > 3'(LB)) || (burst == 2'b11) ||
                  ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   endfunction

   function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
      out_of_range = (a >> LB) >= ADDR_WIDTH'(MEM_DEPTH);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      word_idx = IDX_W'(a >> LB);
   endfunction

   // ---------------- write side ----------------
   w_state_e              w_state_q, w_state_d;
   logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic [7:0]            aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
   logic [2:0]            aw_size_q, aw_size_d;
   logic [1:0]            aw_burst_q, aw_burst_d;
   logic                  w_berr_q, w_berr_d, w_err_q, w_err_d;
   logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [ID_WIDTH-1:0]   bid_q, bid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  mem_we, w_last_beat, w_beat_oob, w_beat_bad;
   logic [IDX_W-1:0]      mem_widx;

   assign w_last_beat = (w_cnt_q == aw_len_q);
   assign w_beat_oob  = out_of_range(aw_addr_q);
   assign w_beat_bad  = w_berr_q | w_beat_oob | (s_axi.WLAST != w_last_beat);
   assign mem_widx    = word_idx(aw_addr_q);

   always_comb begin
      w_state_d  = w_state_q;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      aw_burst_d = aw_burst_q;
      w_berr_d   = w_berr_q;
      w_err_d    = w_err_q;
      w_cnt_d    = w_cnt_q;
      bid_d      = bid_q;
      bresp_d    = bresp_q;
      mem_we     = 1'b0;
      case (w_state_q)
         W_ADDR: if (s_axi.AWVALID && awready_q) begin
            aw_id_d    = s_axi.AWID;
            aw_addr_d  = s_axi.AWADDR;
            aw_len_d   = s_axi.AWLEN;
            aw_size_d  = s_axi.AWSIZE;
            aw_burst_d = s_axi.AWBURST;
            w_berr_d   = burst_err(s_axi.AWLEN, s_axi.AWSIZE, s_axi.AWBURST);
            w_err_d    = 1'b0;
            w_cnt_d    = 8'd0;
            w_state_d  = W_DATA;
         end
         W_DATA: if (s_axi.WVALID && wready_q) begin
            mem_we  = !w_berr_q && !w_beat_oob;
            w_err_d = w_err_q | w_beat_bad;
            // Burst length comes from AWLEN; WLAST only feeds the response.
            if (w_last_beat) begin
               w_state_d = W_RESP;
               bid_d     = aw_id_q;
               bresp_d   = (w_err_q | w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
               aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
               w_cnt_d   = w_cnt_q + 8'd1;
            end
         end
         W_RESP: if (s_axi.BREADY && bvalid_q) w_state_d = W_ADDR;
         default: w_state_d = W_ADDR;
      endcase
      awready_d = (w_state_d == W_ADDR);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q  <= W_ADDR;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
         w_berr_q   <= 1'b0;
         w_err_q    <= 1'b0;
         w_cnt_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         bresp_q    <= '0;
      end else begin
         w_state_q  <= w_state_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         aw_burst_q <= aw_burst_d;
         w_berr_q   <= w_berr_d;
         w_err_q    <= w_err_d;
         w_cnt_q    <= w_cnt_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bid_q      <= bid_d;
         bresp_q    <= bresp_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (s_axi.WSTRB[i]) mem[mem_widx][i*8 +: 8] <= s_axi.WDATA[i*8 +: 8];
         end
      end
   end

   // ---------------- read side ----------------
   r_state_e              r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, r_faddr;
   logic [7:0]            ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
   logic [2:0]            ar_size_q, ar_size_d;
   logic [1:0]            ar_burst_q, ar_burst_d;
   logic                  r_berr_q, r_berr_d, r_fetch;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   always_comb begin
      r_state_d  = r_state_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      r_berr_d   = r_berr_q;
      r_cnt_d    = r_cnt_q;
      rid_d      = rid_q;
      rlast_d    = rlast_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      r_fetch    = 1'b0;
      r_faddr    = ar_addr_q;
      case (r_state_q)
         R_ADDR: if (s_axi.ARVALID && arready_q) begin
            ar_addr_d  = s_axi.ARADDR;
            ar_len_d   = s_axi.ARLEN;
            ar_size_d  = s_axi.ARSIZE;
            ar_burst_d = s_axi.ARBURST;
            r_berr_d   = burst_err(s_axi.ARLEN, s_axi.ARSIZE, s_axi.ARBURST);
            r_cnt_d    = 8'd0;
            rid_d      = s_axi.ARID;
            rlast_d    = (s_axi.ARLEN == 8'd0);
            r_fetch    = 1'b1;
            r_faddr    = s_axi.ARADDR;
            r_state_d  = R_DATA;
         end
         R_DATA: if (s_axi.RREADY && rvalid_q) begin
            if (rlast_q) begin
               rlast_d   = 1'b0;
               r_state_d = R_ADDR;
            end else begin
               r_faddr   = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
               ar_addr_d = r_faddr;
               r_cnt_d   = r_cnt_q + 8'd1;
               rlast_d   = (r_cnt_d == ar_len_q);
               r_fetch   = 1'b1;
            end
         end
         default: r_state_d = R_ADDR;
      endcase
      // A same-edge write lands after this fetch, so the read sees the old word.
      if (r_fetch) begin
         if (r_berr_d || out_of_range(r_faddr)) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end else begin
            rdata_d = mem[word_idx(r_faddr)];
            rresp_d = RESP_OKAY;
         end
      end
      arready_d = (r_state_d == R_ADDR);
      rvalid_d  = (r_state_d == R_DATA);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_q  <= R_ADDR;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         r_berr_q   <= 1'b0;
         r_cnt_q    <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rid_q      <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         r_state_q  <= r_state_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         ar_burst_q <= ar_burst_d;
         r_berr_q   <= r_berr_d;
         r_cnt_q    <= r_cnt_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rlast_q    <= rlast_d;
         rid_q      <= rid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign s_axi.AWREADY = awready_q;
   assign s_axi.WREADY  = wready_q;
   assign s_axi.BVALID  = bvalid_q;
   assign s_axi.BID     = bid_q;
   assign s_axi.BRESP   = bresp_q;
   assign s_axi.ARREADY = arready_q;
   assign s_axi.RVALID  = rvalid_q;
   assign s_axi.RID     = rid_q;
   assign s_axi.RDATA   = rdata_q;
   assign s_axi.RRESP   = rresp_q;
   assign s_axi.RLAST   = rlast_q;

   logic unused_ok;
   assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.WID};
endmodule

// File: tb/tb_axi_slv_mem.sv
// Randomised bench for axi_slv_mem against a word-array reference model with abstract burst addressing.
module tb_axi_slv_mem;
   localparam int DEPTH = 64;
   localparam int TMO   = 200;

   logic ACLK = 1'b0;
   logic ARESET;
   always #5 ACLK = ~ACLK;

   axi_slv_mem_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_slv_mem #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .s_axi  (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] wdat [256];
   logic [3:0]  wstb [256];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit burst_bad(input int len, input int size, input int burst);
      return (size > 2) || (burst == 3) ||
             ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   // Byte address of beat k, straight from the burst definitions.
   function automatic longint beat_addr(input longint addr, input int len, input int size,
                                        input int burst, input int k);
      longint step, cont, base;
      step = longint'(1) << size;
      if (burst == 0) return addr;
      if (burst == 2) begin
         cont = (len + 1) * step;
         base = addr - (addr % cont);
         return base + ((addr % cont) + k * step) % cont;
      end
      return addr + k * step;
   endfunction

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int early_last, input int b_hold);
      bit berr, err, wl;
      longint a, idx;
      int t;
      logic [3:0] got_bid;
      logic [1:0] got_resp, exp_resp;
      berr = burst_bad(len, size, burst);
      err  = berr;
      for (int k = 0; k <= len; k++) begin
         a   = beat_addr(longint'(addr), len, size, burst, k);
         idx = a >> 2;
         wl  = (early_last >= 0) ? (k == early_last) : (k == len);
         if (wl != (k == len)) err = 1'b1;
         if (idx >= DEPTH) err = 1'b1;
         else if (!berr)
            for (int b = 0; b < 4; b++)
               if (wstb[k][b]) ref_mem[idx][b*8 +: 8] = wdat[k][b*8 +: 8];
      end
      exp_resp = err ? 2'b10 : 2'b00;

      @(negedge ACLK);
      bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = 8'(len);
      bus.AWSIZE = 3'(size); bus.AWBURST = 2'(burst); bus.AWVALID = 1'b1;
      t = 0;
      while (!bus.AWREADY && t < TMO) begin @(negedge ACLK); t++; end
      check("aw_accept", 64'(t < TMO), 64'd1);
      @(negedge ACLK);
      bus.AWVALID = 1'b0;
      check("aw_closed", 64'(bus.AWREADY), 64'd0);
      for (int k = 0; k <= len; k++) begin
         repeat ($urandom_range(0, 1)) @(negedge ACLK);
         bus.WDATA = wdat[k]; bus.WSTRB = wstb[k];
         bus.WLAST = (early_last >= 0) ? (k == early_last) : (k == len);
         bus.WVALID = 1'b1;
         t = 0;
         while (!bus.WREADY && t < TMO) begin @(negedge ACLK); t++; end
         if (t >= TMO) check("w_accept", 64'(t < TMO), 64'd1);
         @(negedge ACLK);
         bus.WVALID = 1'b0; bus.WLAST = 1'b0;
      end
      t = 0;
      while (!bus.BVALID && t < TMO) begin @(negedge ACLK); t++; end
      check("b_valid", 64'(t < TMO), 64'd1);
      check("w_closed", 64'(bus.WREADY), 64'd0);
      got_bid  = bus.BID;
      got_resp = bus.BRESP;
      for (int c = 0; c < b_hold; c++) begin
         @(negedge ACLK);
         check("b_hold_vld", 64'(bus.BVALID), 64'd1);
         check("b_hold_id", 64'(bus.BID), 64'(id));
         check("b_hold_resp", 64'(bus.BRESP), 64'(exp_resp));
         check("b_hold_awrdy", 64'(bus.AWREADY), 64'd0);
      end
      check("bid", 64'(got_bid), 64'(id));
      check("bresp", 64'(got_resp), 64'(exp_resp));
      bus.BREADY = 1'b1;
      @(negedge ACLK);
      bus.BREADY = 1'b0;
      check("b_done_vld", 64'(bus.BVALID), 64'd0);
      check("b_done_awrdy", 64'(bus.AWREADY), 64'd1);
   endtask

   // abort_at >= 0: assert ARESET while beat abort_at is being presented.
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int abort_at);
      bit berr, bad;
      longint a, idx;
      int t;
      logic [31:0] exp_d;
      logic [1:0] exp_r;
      berr = burst_bad(len, size, burst);
      @(negedge ACLK);
      bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = 8'(len);
      bus.ARSIZE = 3'(size); bus.ARBURST = 2'(burst); bus.ARVALID = 1'b1;
      t = 0;
      while (!bus.ARREADY && t < TMO) begin @(negedge ACLK); t++; end
      check("ar_accept", 64'(t < TMO), 64'd1);
      @(negedge ACLK);
      bus.ARVALID = 1'b0;
      check("ar_closed", 64'(bus.ARREADY), 64'd0);
      for (int k = 0; k <= len; k++) begin
         a     = beat_addr(longint'(addr), len, size, burst, k);
         idx   = a >> 2;
         bad   = berr || (idx >= DEPTH);
         exp_d = bad ? 32'h0 : ref_mem[idx];
         exp_r = bad ? 2'b10 : 2'b00;
         t = 0;
         while (!bus.RVALID && t < TMO) begin @(negedge ACLK); t++; end
         check("r_valid", 64'(t < TMO), 64'd1);
         if (k == abort_at) begin
            #2 ARESET = 1'b1;
            #1;
            check("rst_rvalid", 64'(bus.RVALID), 64'd0);
            check("rst_rlast", 64'(bus.RLAST), 64'd0);
            check("rst_rdata", 64'(bus.RDATA), 64'd0);
            check("rst_arrdy", 64'(bus.ARREADY), 64'd0);
            return;
         end
         repeat ($urandom_range(0, 2)) @(negedge ACLK);
         check($sformatf("rid[%0d]", k), 64'(bus.RID), 64'(id));
         check($sformatf("rdata[%0d]@%0h", k, a), 64'(bus.RDATA), 64'(exp_d));
         check($sformatf("rresp[%0d]", k), 64'(bus.RRESP), 64'(exp_r));
         check($sformatf("rlast[%0d]", k), 64'(bus.RLAST), 64'(k == len));
         bus.RREADY = 1'b1;
         @(negedge ACLK);
         bus.RREADY = 1'b0;
      end
      check("r_done_vld", 64'(bus.RVALID), 64'd0);
      check("r_done_arrdy", 64'(bus.ARREADY), 64'd1);
   endtask

   initial begin
      int len, size, burst, el, sel;
      logic [31:0] addr;
      ARESET = 1'b1;
      bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
      bus.AWPROT = '0; bus.AWVALID = 1'b0; bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0;
      bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARID = '0; bus.ARADDR = '0;
      bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;
      repeat (3) @(negedge ACLK);
      check("rst_awready", 64'(bus.AWREADY), 64'd0);
      check("rst_wready", 64'(bus.WREADY), 64'd0);
      check("rst_bvalid", 64'(bus.BVALID), 64'd0);
      check("rst_bid_bresp", 64'({bus.BID, bus.BRESP}), 64'd0);
      check("rst_arready", 64'(bus.ARREADY), 64'd0);
      check("rst_rvalid", 64'(bus.RVALID), 64'd0);
      check("rst_rpayload", 64'({bus.RID, bus.RDATA, bus.RRESP, bus.RLAST}), 64'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rel_awready", 64'(bus.AWREADY), 64'd1);
      check("rel_arready", 64'(bus.ARREADY), 64'd1);

      // Preload every word so the model knows the whole array.
      for (int blk = 0; blk < DEPTH / 16; blk++) begin
         for (int k = 0; k < 16; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
         do_write(4'(blk), 32'(blk * 64), 15, 2, 1, -1, 0);
      end

      for (int k = 0; k < 4; k++) begin wdat[k] = 32'hA0 + 32'(k); wstb[k] = 4'hF; end
      do_write(4'h3, 32'h10, 3, 2, 1, -1, 0);
      do_read(4'h5, 32'h10, 3, 2, 1, -1);
      do_read(4'h6, 32'h18, 3, 2, 2, -1);

      wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
      do_write(4'h1, 32'h40, 0, 2, 1, -1, 0);
      wdat[0] = 32'h1122_3344; wstb[0] = 4'h5;
      do_write(4'h1, 32'h40, 0, 2, 1, -1, 0);
      do_read(4'h2, 32'h40, 0, 2, 1, -1);
      for (int k = 0; k < 3; k++) begin wdat[k] = 32'hB0 + 32'(k); wstb[k] = 4'hF; end
      do_write(4'h7, 32'h44, 2, 2, 0, -1, 0);
      do_read(4'h7, 32'h44, 0, 2, 1, -1);

      do_read(4'h8, 32'(DEPTH * 4 - 4), 1, 2, 1, -1);
      do_read(4'h9, 32'h10, 2, 2, 2, -1);

      for (int k = 0; k < 4; k++) begin wdat[k] = 32'hC0 + 32'(k); wstb[k] = 4'hF; end
      do_write(4'hA, 32'h20, 3, 2, 1, 1, 5);
      do_read(4'hA, 32'h20, 3, 2, 1, -1);

      do_read(4'hB, 32'h10, 3, 2, 1, 2);
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rst2_awready", 64'(bus.AWREADY), 64'd1);
      check("rst2_arready", 64'(bus.ARREADY), 64'd1);
      do_read(4'hC, 32'h10, 3, 2, 1, -1);

      for (int n = 0; n < 40; n++) begin
         sel   = $urandom_range(0, 9);
         burst = (sel < 2) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
         size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         if (burst == 2) begin
            case ($urandom_range(0, 3))
               0: len = 1;
               1: len = 3;
               2: len = 7;
               default: len = 2;
            endcase
         end else begin
            len = $urandom_range(0, 7);
         end
         addr = 32'($urandom_range(0, DEPTH * 4 + 31));
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k <= len; k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
            el = (len > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
            do_write(4'($urandom), addr, len, size, burst, el, $urandom_range(0, 2));
         end else begin
            do_read(4'($urandom), addr, len, size, burst, -1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
